// File: rtl/prco_lmem_ctrl.sv
// rtl/prco_lmem_ctrl.sv - prco local-memory access initiator (fetch + load/store)
// Owns the PC and serialises fetch and load/store requests onto the single-port local memory.
module prco_lmem_ctrl #(
  parameter logic [15:0] P_RESET_PC = 16'h0000,
  parameter int          P_TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fetch_req,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [15:0] i_ls_addr,
  input  logic [15:0] i_ls_data,
  input  logic        i_branch,
  input  logic [15:0] i_branch_target,
  output logic        q_ce_fetch,
  output logic        q_ce_alu,
  output logic        q_mem_we,
  output logic [15:0] q_mem_addr,
  output logic [15:0] q_mem_dina,
  input  logic        i_ce_dec,
  input  logic        i_ce_reg,
  input  logic [15:0] i_mem_douta,
  output logic [15:0] q_pc,
  output logic [15:0] q_instr,
  output logic        q_instr_valid,
  output logic [15:0] q_ld_data,
  output logic        q_ld_valid,
  output logic        q_busy,
  output logic        q_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LS} state_t;

  localparam logic [7:0] LP_TMO_LAST = 8'(P_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic        r_fetch_pend, r_ls_pend, r_ls_we, r_squash;
  logic [15:0] r_ls_addr, r_ls_data;
  logic [7:0]  r_tmo_cnt;
  logic        r_ce_fetch, r_ce_alu, r_mem_we, r_instr_valid, r_ld_valid, r_timeout;
  logic [15:0] r_mem_addr, r_mem_dina, r_pc, r_instr, r_ld_data;

  logic        w_issue_fetch, w_issue_ls, w_fetch_done, w_ls_done, w_tmo;
  logic        w_ls_we;
  logic [15:0] w_ls_addr, w_ls_data, w_fetch_addr;

  // A same-cycle request bypasses the pending register; a same-cycle branch redirects the fetch.
  assign w_ls_we      = r_ls_pend ? r_ls_we   : i_ls_we;
  assign w_ls_addr    = r_ls_pend ? r_ls_addr : i_ls_addr;
  assign w_ls_data    = r_ls_pend ? r_ls_data : i_ls_data;
  assign w_fetch_addr = i_branch  ? i_branch_target : r_pc;

  always_comb begin
    w_state_nxt   = r_state;
    w_issue_fetch = 1'b0;
    w_issue_ls    = 1'b0;
    w_fetch_done  = 1'b0;
    w_ls_done     = 1'b0;
    w_tmo         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ls_pend || i_ls_req) begin
          w_state_nxt = S_LS;
          w_issue_ls  = 1'b1;
        end else if (r_fetch_pend || i_fetch_req) begin
          w_state_nxt   = S_FETCH;
          w_issue_fetch = 1'b1;
        end
      end
      S_FETCH: begin
        if (i_ce_dec) begin
          w_fetch_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (r_tmo_cnt == LP_TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_LS: begin
        if (i_ce_reg) begin
          w_ls_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tmo_cnt == LP_TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_fetch_pend  <= 1'b0;
      r_ls_pend     <= 1'b0;
      r_ls_we       <= 1'b0;
      r_ls_addr     <= 16'h0000;
      r_ls_data     <= 16'h0000;
      r_squash      <= 1'b0;
      r_tmo_cnt     <= 8'd0;
      r_ce_fetch    <= 1'b0;
      r_ce_alu      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 16'h0000;
      r_mem_dina    <= 16'h0000;
      r_pc          <= P_RESET_PC;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_ld_data     <= 16'h0000;
      r_ld_valid    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ce_fetch    <= w_issue_fetch;
      r_ce_alu      <= w_issue_ls;
      r_instr_valid <= 1'b0;
      r_ld_valid    <= 1'b0;

      if (w_issue_fetch) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= w_fetch_addr;
      end else if (w_issue_ls) begin
        r_mem_we   <= w_ls_we;
        r_mem_addr <= w_ls_addr;
        r_mem_dina <= w_ls_data;
      end

      if (w_issue_fetch || w_issue_ls)
        r_tmo_cnt <= 8'd0;
      else if (r_state != S_IDLE)
        r_tmo_cnt <= r_tmo_cnt + 8'd1;

      if (w_fetch_done || (w_tmo && r_state == S_FETCH))
        r_fetch_pend <= 1'b0;
      else if (i_fetch_req)
        r_fetch_pend <= 1'b1;

      if (w_ls_done || (w_tmo && r_state == S_LS)) begin
        r_ls_pend <= 1'b0;
      end else if (i_ls_req && !r_ls_pend) begin
        r_ls_pend <= 1'b1;
        r_ls_we   <= i_ls_we;
        r_ls_addr <= i_ls_addr;
        r_ls_data <= i_ls_data;
      end

      // A branch while a fetch is on the memory side marks its eventual result as stale.
      if (w_issue_fetch)
        r_squash <= 1'b0;
      else if (r_state == S_FETCH && i_branch)
        r_squash <= 1'b1;

      if (w_fetch_done && !r_squash && !i_branch) begin
        r_instr       <= i_mem_douta;
        r_instr_valid <= 1'b1;
      end

      if (i_branch)
        r_pc <= i_branch_target;
      else if (w_fetch_done && !r_squash)
        r_pc <= r_pc + 16'd1;

      if (w_ls_done) begin
        r_ld_valid <= 1'b1;
        if (!r_ls_we)
          r_ld_data <= i_mem_douta;
      end

      if (w_tmo)
        r_timeout <= 1'b1;
    end
  end

  assign q_ce_fetch    = r_ce_fetch;
  assign q_ce_alu      = r_ce_alu;
  assign q_mem_we      = r_mem_we;
  assign q_mem_addr    = r_mem_addr;
  assign q_mem_dina    = r_mem_dina;
  assign q_pc          = r_pc;
  assign q_instr       = r_instr;
  assign q_instr_valid = r_instr_valid;
  assign q_ld_data     = r_ld_data;
  assign q_ld_valid    = r_ld_valid;
  assign q_timeout     = r_timeout;
  assign q_busy        = (r_state != S_IDLE) || r_fetch_pend || r_ls_pend;
endmodule

// File: tb/tb_prco_lmem_ctrl.sv
// tb/tb_prco_lmem_ctrl.sv - self-checking bench for prco_lmem_ctrl
// Directed literal scenarios, then randomized traffic against a transaction-level model.
module tb_prco_lmem_ctrl;
  localparam int P_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fetch_req = 0, i_ls_req = 0, i_ls_we = 0, i_branch = 0;
  logic [15:0] i_ls_addr = 0, i_ls_data = 0, i_branch_target = 0;
  logic        dir_dec = 0, dir_reg = 0, rsp_dec = 0, rsp_reg = 0;
  logic [15:0] dir_data = 0, rsp_data = 0;
  logic        resp_en = 0, chk_en = 0;
  logic        i_ce_dec, i_ce_reg;
  logic [15:0] i_mem_douta;
  logic        q_ce_fetch, q_ce_alu, q_mem_we, q_instr_valid, q_ld_valid, q_busy, q_timeout;
  logic [15:0] q_mem_addr, q_mem_dina, q_pc, q_instr, q_ld_data;

  int nvec = 0, nmis = 0;

  assign i_ce_dec    = resp_en ? rsp_dec  : dir_dec;
  assign i_ce_reg    = resp_en ? rsp_reg  : dir_reg;
  assign i_mem_douta = resp_en ? rsp_data : dir_data;

  prco_lmem_ctrl #(.P_RESET_PC(16'h0000), .P_TIMEOUT(P_TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_fetch_req(i_fetch_req), .i_ls_req(i_ls_req), .i_ls_we(i_ls_we),
    .i_ls_addr(i_ls_addr), .i_ls_data(i_ls_data),
    .i_branch(i_branch), .i_branch_target(i_branch_target),
    .q_ce_fetch(q_ce_fetch), .q_ce_alu(q_ce_alu), .q_mem_we(q_mem_we),
    .q_mem_addr(q_mem_addr), .q_mem_dina(q_mem_dina),
    .i_ce_dec(i_ce_dec), .i_ce_reg(i_ce_reg), .i_mem_douta(i_mem_douta),
    .q_pc(q_pc), .q_instr(q_instr), .q_instr_valid(q_instr_valid),
    .q_ld_data(q_ld_data), .q_ld_valid(q_ld_valid),
    .q_busy(q_busy), .q_timeout(q_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory answers one cycle after the strobe with the given word.
  task automatic respond(input bit is_ls, input logic [15:0] data);
    tick();
    if (is_ls) dir_reg = 1'b1; else dir_dec = 1'b1;
    dir_data = data;
    tick();
    dir_dec = 1'b0;
    dir_reg = 1'b0;
  endtask

  // Model: at most one access outstanding at the memory (kind 0 none, 1 fetch, 2 ls).
  int          m_kind, m_age;
  bit          m_sq, m_fp, m_lp, m_lwe, m_tmo, m_we;
  logic [15:0] m_laddr, m_ldata, m_pc, m_instr, m_ld, m_addr, m_dina;

  task automatic model_reset();
    m_kind = 0; m_age = 0; m_sq = 0; m_fp = 0; m_lp = 0; m_lwe = 0; m_tmo = 0; m_we = 0;
    m_laddr = 0; m_ldata = 0; m_pc = 16'h0000; m_instr = 0; m_ld = 0; m_addr = 0; m_dina = 0;
  endtask

  task automatic step_check();
    bit fdone, ldone, tmo, was_f, ef, el, eiv, elv, ofp, olp;
    ofp = m_fp;
    olp = m_lp;
    was_f = (m_kind == 1);
    fdone = (m_kind == 1) && i_ce_dec;
    ldone = (m_kind == 2) && i_ce_reg;
    tmo = (m_kind != 0) && !fdone && !ldone && (m_age == P_TIMEOUT - 1);
    ef = 0; el = 0; eiv = 0; elv = 0;
    if (i_fetch_req && !ofp) m_fp = 1;
    if (i_ls_req && !olp) begin
      m_lp = 1; m_lwe = i_ls_we; m_laddr = i_ls_addr; m_ldata = i_ls_data;
    end
    if (fdone) begin
      if (!m_sq && !i_branch) begin
        eiv = 1; m_instr = i_mem_douta; m_pc = m_pc + 16'd1;
      end
      m_fp = 0; m_kind = 0;
    end else if (ldone) begin
      elv = 1;
      if (!m_lwe) m_ld = i_mem_douta;
      m_lp = 0; m_kind = 0;
    end else if (tmo) begin
      m_tmo = 1;
      if (m_kind == 1) m_fp = 0; else m_lp = 0;
      m_kind = 0;
    end else if (m_kind == 0) begin
      if (m_lp) begin
        el = 1; m_kind = 2; m_age = 0;
        m_we = m_lwe; m_addr = m_laddr; m_dina = m_ldata;
      end else if (m_fp) begin
        ef = 1; m_kind = 1; m_age = 0; m_sq = 0;
        m_we = 0; m_addr = i_branch ? i_branch_target : m_pc;
      end
    end else begin
      m_age++;
    end
    if (was_f && !fdone && !tmo && i_branch) m_sq = 1;
    if (i_branch) m_pc = i_branch_target;

    chk("rnd_ce_fetch", q_ce_fetch, ef);
    chk("rnd_ce_alu", q_ce_alu, el);
    chk("rnd_mem_we", q_mem_we, m_we);
    chk("rnd_mem_addr", q_mem_addr, m_addr);
    chk("rnd_mem_dina", q_mem_dina, m_dina);
    chk("rnd_instr_valid", q_instr_valid, eiv);
    chk("rnd_instr", q_instr, m_instr);
    chk("rnd_ld_valid", q_ld_valid, elv);
    chk("rnd_ld_data", q_ld_data, m_ld);
    chk("rnd_pc", q_pc, m_pc);
    chk("rnd_busy", q_busy, (m_kind != 0) || m_fp || m_lp);
    chk("rnd_timeout", q_timeout, m_tmo);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) step_check();
  end

  // Random-phase memory: answers after 1..3 cycles, sometimes never, sometimes with the wrong strobe.
  logic [15:0] mem [0:63];
  int          r_kind = 0, r_cnt = 0;
  logic [5:0]  r_addr = 0;

  always @(posedge clk) begin
    #3;
    if (resp_en) begin
      rsp_dec = 0;
      rsp_reg = 0;
      rsp_data = 16'($urandom);
      if (q_ce_fetch || q_ce_alu) begin
        r_kind = q_ce_fetch ? 1 : 2;
        r_addr = q_mem_addr[5:0];
        if (q_ce_alu && q_mem_we) mem[r_addr] = q_mem_dina;
        r_cnt = ($urandom % 16 == 0) ? 0 : int'($urandom_range(1, 3));
      end else if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0) begin
          if (r_kind == 1) rsp_dec = 1; else rsp_reg = 1;
          rsp_data = mem[r_addr];
        end
      end
      if (!rsp_dec && !rsp_reg && ($urandom % 8 == 0)) begin
        if (r_kind == 1) rsp_reg = 1; else rsp_dec = 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    rst = 1'b1;
    #7;
    chk("rst_pc", q_pc, 16'h0000);
    chk("rst_busy", q_busy, 1'b0);
    chk("rst_timeout", q_timeout, 1'b0);
    chk("rst_ce_fetch", q_ce_fetch, 1'b0);
    chk("rst_instr_valid", q_instr_valid, 1'b0);
    tick();
    rst = 1'b0;

    // First fetch at reset PC.
    i_fetch_req = 1;
    tick();
    i_fetch_req = 0;
    chk("f1_ce_fetch", q_ce_fetch, 1'b1);
    chk("f1_addr", q_mem_addr, 16'h0000);
    chk("f1_we", q_mem_we, 1'b0);
    chk("f1_busy", q_busy, 1'b1);
    tick();
    dir_dec = 1; dir_data = 16'h20ab;
    chk("f1_valid_early", q_instr_valid, 1'b0);
    tick();
    dir_dec = 0;
    chk("f1_valid", q_instr_valid, 1'b1);
    chk("f1_instr", q_instr, 16'h20ab);
    chk("f1_pc", q_pc, 16'h0001);
    chk("f1_busy_end", q_busy, 1'b0);

    // Store then load the same address.
    i_ls_req = 1; i_ls_we = 1; i_ls_addr = 16'h0010; i_ls_data = 16'h1234;
    tick();
    i_ls_req = 0;
    chk("st_ce_alu", q_ce_alu, 1'b1);
    chk("st_we", q_mem_we, 1'b1);
    chk("st_addr", q_mem_addr, 16'h0010);
    chk("st_dina", q_mem_dina, 16'h1234);
    respond(1, 16'hdead);
    chk("st_valid", q_ld_valid, 1'b1);
    chk("st_ld_data_kept", q_ld_data, 16'h0000);
    i_ls_req = 1; i_ls_we = 0;
    tick();
    i_ls_req = 0;
    chk("ld_ce_alu", q_ce_alu, 1'b1);
    chk("ld_we", q_mem_we, 1'b0);
    respond(1, 16'h1234);
    chk("ld_valid", q_ld_valid, 1'b1);
    chk("ld_data", q_ld_data, 16'h1234);

    // Simultaneous fetch and load: load first.
    i_fetch_req = 1; i_ls_req = 1; i_ls_we = 0; i_ls_addr = 16'h0020;
    tick();
    i_fetch_req = 0; i_ls_req = 0;
    chk("both_ce_alu", q_ce_alu, 1'b1);
    chk("both_ce_fetch0", q_ce_fetch, 1'b0);
    respond(1, 16'h5555);
    chk("both_ld_valid", q_ld_valid, 1'b1);
    chk("both_ld_data", q_ld_data, 16'h5555);
    chk("both_busy", q_busy, 1'b1);
    tick();
    chk("both_ce_fetch", q_ce_fetch, 1'b1);
    chk("both_fetch_addr", q_mem_addr, 16'h0001);
    respond(0, 16'h7777);
    chk("both_instr_valid", q_instr_valid, 1'b1);
    chk("both_instr", q_instr, 16'h7777);
    chk("both_pc", q_pc, 16'h0002);

    // Branch squashes an in-flight fetch.
    i_fetch_req = 1;
    tick();
    i_fetch_req = 0;
    chk("br_fetch_addr", q_mem_addr, 16'h0002);
    i_branch = 1; i_branch_target = 16'h0005;
    tick();
    i_branch = 0;
    chk("br_pc", q_pc, 16'h0005);
    dir_dec = 1; dir_data = 16'h1111;
    tick();
    dir_dec = 0;
    chk("br_squashed", q_instr_valid, 1'b0);
    chk("br_pc_hold", q_pc, 16'h0005);
    chk("br_busy", q_busy, 1'b0);
    i_fetch_req = 1;
    tick();
    i_fetch_req = 0;
    chk("br_new_addr", q_mem_addr, 16'h0005);
    respond(0, 16'h2222);
    chk("br_new_valid", q_instr_valid, 1'b1);
    chk("br_new_pc", q_pc, 16'h0006);

    // PC wraps FFFF -> 0000.
    i_branch = 1; i_branch_target = 16'hffff;
    tick();
    i_branch = 0;
    chk("wrap_pc_pre", q_pc, 16'hffff);
    i_fetch_req = 1;
    tick();
    i_fetch_req = 0;
    chk("wrap_addr", q_mem_addr, 16'hffff);
    respond(0, 16'h3c3c);
    chk("wrap_valid", q_instr_valid, 1'b1);
    chk("wrap_pc", q_pc, 16'h0000);

    // Withheld completion strobe times out.
    i_fetch_req = 1;
    tick();
    i_fetch_req = 0;
    chk("tmo_strobe", q_ce_fetch, 1'b1);
    for (int k = 1; k < P_TIMEOUT; k++) begin
      tick();
      chk("tmo_not_yet", q_timeout, 1'b0);
    end
    tick();
    chk("tmo_set", q_timeout, 1'b1);
    chk("tmo_busy", q_busy, 1'b0);
    chk("tmo_no_valid", q_instr_valid, 1'b0);
    i_fetch_req = 1;
    tick();
    i_fetch_req = 0;
    chk("tmo_refetch_addr", q_mem_addr, 16'h0000);
    respond(0, 16'h4242);
    chk("tmo_refetch_valid", q_instr_valid, 1'b1);
    chk("tmo_refetch_pc", q_pc, 16'h0001);
    chk("tmo_sticky", q_timeout, 1'b1);

    // Reset mid-transaction; late strobe afterwards is ignored.
    i_fetch_req = 1;
    tick();
    i_fetch_req = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_ce_fetch", q_ce_fetch, 1'b0);
    chk("mrst_pc", q_pc, 16'h0000);
    chk("mrst_timeout", q_timeout, 1'b0);
    chk("mrst_busy", q_busy, 1'b0);
    tick();
    rst = 1'b0;
    dir_dec = 1; dir_data = 16'h9999;
    tick();
    dir_dec = 0;
    tick();
    chk("mrst_no_valid", q_instr_valid, 1'b0);
    chk("mrst_instr", q_instr, 16'h0000);
    chk("mrst_idle", q_busy, 1'b0);

    // Randomized traffic against the model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    resp_en = 1;
    chk_en = 1;
    repeat (3000) begin
      @(posedge clk);
      #3;
      i_fetch_req = ($urandom % 4 == 0);
      i_ls_req = ($urandom % 5 == 0);
      i_ls_we = $urandom % 2;
      i_ls_addr = 16'($urandom_range(0, 63));
      i_ls_data = 16'($urandom);
      i_branch = ($urandom % 12 == 0);
      i_branch_target = ($urandom % 4 == 0) ? 16'hffff : 16'($urandom);
    end
    @(posedge clk);
    #2;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/prco_lmem_ctrl.md
# prco_lmem_ctrl

Memory-access initiator for the prco core's single-port local memory. It owns the program counter, accepts instruction-fetch and load/store requests from the pipeline, serialises them onto the memory's fetch/ALU strobe port, and matches each request to its decode/register completion strobe. Results return to the pipeline as one-cycle valid pulses. It sits between the pipeline control and the local memory.

## Interface

- P_RESET_PC, 16'h0000, PC value after reset
- P_TIMEOUT, 15, max cycles to wait for a completion strobe before aborting (1..255)
- i_clk  in  1  core clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_fetch_req  in  1  pulse: fetch instruction at q_pc
- i_ls_req  in  1  pulse: load/store request
- i_ls_we  in  1  1 = store, 0 = load; sampled with i_ls_req
- i_ls_addr  in  16  load/store address; sampled with i_ls_req
- i_ls_data  in  16  store data; sampled with i_ls_req
- i_branch  in  1  pulse: redirect PC
- i_branch_target  in  16  new PC; sampled with i_branch
- q_ce_fetch  out  1  to memory: fetch-class access strobe
- q_ce_alu  out  1  to memory: ALU-class (load/store) access strobe
- q_mem_we  out  1  to memory: write enable
- q_mem_addr  out  16  to memory: address
- q_mem_dina  out  16  to memory: write data
- i_ce_dec  in  1  from memory: fetch completion strobe
- i_ce_reg  in  1  from memory: load/store completion strobe
- i_mem_douta  in  16  from memory: read data, valid with completion strobe
- q_pc  out  16  current PC
- q_instr  out  16  fetched instruction
- q_instr_valid  out  1  one-cycle pulse, q_instr valid
- q_ld_data  out  16  load result
- q_ld_valid  out  1  one-cycle pulse, load or store complete (q_ld_data meaningful for loads only)
- q_busy  out  1  state != IDLE or any request pending
- q_timeout  out  1  sticky: a completion strobe timed out; cleared by reset only

## Operation

- Pending registers: one fetch-pending and one ls-pending flag (with captured we/addr/data). A request pulse sets its flag; a second pulse of the same kind while pending is dropped.
- FSM states: IDLE, FETCH, LS.
- IDLE: if ls-pending (or i_ls_req this cycle) go LS; else if fetch-pending (or i_fetch_req this cycle) go FETCH. Load/store has priority over fetch. Same-cycle request bypasses the pending register.
- On entering FETCH: q_ce_fetch=1 for exactly one cycle, q_mem_addr=q_pc, q_mem_we=0. On entering LS: q_ce_alu=1 for one cycle, addr/we/data from the captured request. All memory-side outputs are registered.
- FETCH: wait for i_ce_dec. On it: q_instr<=i_mem_douta, q_instr_valid pulses, q_pc<=q_pc+1 (16-bit wrap FFFF->0000), clear fetch-pending, go IDLE.
- LS: wait for i_ce_reg. On it: q_ld_data<=i_mem_douta (loads only; unchanged for stores), q_ld_valid pulses, clear ls-pending, go IDLE.
- The mismatched strobe (i_ce_reg in FETCH, i_ce_dec in LS, either in IDLE) is ignored.
- Branch: q_pc<=i_branch_target next cycle; any fetch in flight completes on the memory side but is squashed (no q_instr_valid, no PC increment); a pending-but-unissued fetch stays pending and uses the new PC. Branch and fetch completion in the same cycle: branch wins.
- Timeout: counter cleared on entering FETCH/LS; if it reaches P_TIMEOUT without the matching strobe, set q_timeout, drop that request's pending flag, go IDLE with no valid pulse.

## Timing

- Reset (async): state IDLE, pending flags 0, q_pc=P_RESET_PC, all other outputs 0.
- Fetch latency with memory responding one cycle after strobe: i_fetch_req at cycle 0 -> q_ce_fetch cycle 1 -> i_ce_dec cycle 2 -> q_instr_valid cycle 3, q_pc updated cycle 3.
- Load/store latency identical (q_ce_alu cycle 1, q_ld_valid cycle 3).
- Back-to-back: next strobe issues at the earliest on the cycle q_*_valid is high (IDLE one cycle), i.e. issue interval 2 cycles minimum.
- Reset asserted mid-transaction: aborted immediately, no valid pulses; late completion strobes after reset are ignored (state IDLE).

## Test plan

- Reset then i_fetch_req with memory word 0 = 16'h20ab -> q_ce_fetch cycle 1 addr 0000, q_instr=20ab valid cycle 3, q_pc=0001.
- Store 16'h1234 to 0x0010 then load 0x0010 -> q_mem_we=1 on store strobe, q_ld_valid twice, q_ld_data=1234 after load.
- i_fetch_req and i_ls_req same cycle -> q_ce_alu issued first, fetch issued after q_ld_valid; both complete.
- Fetch in flight, i_branch to 0x0005 -> no q_instr_valid for it, q_pc=0005; next fetch reads addr 0005.
- q_pc=FFFF, fetch completes -> q_pc=0000.
- Memory withholds i_ce_dec -> q_timeout set P_TIMEOUT cycles after strobe, q_busy drops, later i_fetch_req works normally.
